// File: rtl/vx_mshr_linked.sv
// rtl/vx_mshr_linked.sv - miss status holding register with per-line linked miss chains
module vx_mshr_linked #(
   parameter int MSHR_SIZE       = 8,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int DATA_WIDTH      = 64,
   parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE)
) (
   input  logic                       clk,
   input  logic                       reset,

   input  logic                       allocate_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
   input  logic [DATA_WIDTH-1:0]      allocate_data,
   output logic                       allocate_ready,
   output logic [MSHR_ADDR_WIDTH-1:0] allocate_id,
   output logic                       allocate_pending,

   input  logic                       fill_valid,
   input  logic [MSHR_ADDR_WIDTH-1:0] fill_id,
   output logic                       fill_ready,

   output logic                       dequeue_valid,
   input  logic                       dequeue_ready,
   output logic [MSHR_ADDR_WIDTH-1:0] dequeue_id,
   output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
   output logic [DATA_WIDTH-1:0]      dequeue_data,

   output logic                       full,
   output logic                       empty,
   output logic [MSHR_ADDR_WIDTH:0]   count
);

   localparam int CW = MSHR_ADDR_WIDTH + 1;

   // Control state (reset)
   logic [MSHR_SIZE-1:0]       valid_q, valid_d;
   logic [MSHR_SIZE-1:0]       next_valid_q, next_valid_d;
   logic [MSHR_SIZE-1:0]       draining_q, draining_d;
   logic                       dequeue_valid_q, dequeue_valid_d;
   logic [MSHR_ADDR_WIDTH-1:0] dequeue_id_q, dequeue_id_d;
   logic [CW-1:0]              count_q, count_d;

   // Payload storage (no reset)
   logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
   logic [LINE_ADDR_WIDTH-1:0] addr_d [MSHR_SIZE];
   logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
   logic [DATA_WIDTH-1:0]      data_d [MSHR_SIZE];
   logic [MSHR_ADDR_WIDTH-1:0] next_q [MSHR_SIZE];
   logic [MSHR_ADDR_WIDTH-1:0] next_d [MSHR_SIZE];

   logic                       free_found;
   logic [MSHR_ADDR_WIDTH-1:0] free_id;
   logic                       tail_hit;
   logic [MSHR_ADDR_WIDTH-1:0] tail_id;
   logic                       fill_is_linked;
   logic [LINE_ADDR_WIDTH-1:0] fill_addr;
   logic                       alloc_fire;
   logic                       fill_fire;
   logic                       deq_fire;

   assign full             = (count_q == CW'(MSHR_SIZE));
   assign empty            = (count_q == '0);
   assign count            = count_q;
   assign allocate_ready   = ~full;
   assign allocate_id      = free_id;
   assign allocate_pending = tail_hit;
   assign fill_ready       = ~dequeue_valid_q;
   assign dequeue_valid    = dequeue_valid_q;
   assign dequeue_id       = dequeue_id_q;
   assign dequeue_addr     = addr_q[dequeue_id_q];
   assign dequeue_data     = data_q[dequeue_id_q];
   assign fill_addr        = addr_q[fill_id];

   assign alloc_fire = allocate_valid && allocate_ready;
   assign fill_fire  = fill_valid && fill_ready;
   assign deq_fire   = dequeue_valid_q && dequeue_ready;

   // Lowest free slot; a slot being dequeued this cycle still looks valid, so it is not reissued
   always_comb begin
      free_found = 1'b0;
      free_id    = '0;
      for (int i = 0; i < MSHR_SIZE; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_id    = MSHR_ADDR_WIDTH'(i);
         end
      end
   end

   // Open tail of a not-yet-filled chain for the allocating line; draining chains are closed
   always_comb begin
      tail_hit = 1'b0;
      tail_id  = '0;
      for (int i = 0; i < MSHR_SIZE; i++) begin
         if (valid_q[i] && !draining_q[i] && !next_valid_q[i] &&
             (addr_q[i] == allocate_addr) && !tail_hit) begin
            tail_hit = 1'b1;
            tail_id  = MSHR_ADDR_WIDTH'(i);
         end
      end
   end

   // Whether the filled entry is some other entry's successor (i.e. not a chain head)
   always_comb begin
      fill_is_linked = 1'b0;
      for (int j = 0; j < MSHR_SIZE; j++) begin
         if (valid_q[j] && next_valid_q[j] && (next_q[j] == fill_id)) begin
            fill_is_linked = 1'b1;
         end
      end
   end

   // Next-state for entries, dequeue pointer and occupancy count
   always_comb begin
      valid_d         = valid_q;
      next_valid_d    = next_valid_q;
      draining_d      = draining_q;
      addr_d          = addr_q;
      data_d          = data_q;
      next_d          = next_q;
      dequeue_valid_d = dequeue_valid_q;
      dequeue_id_d    = dequeue_id_q;
      count_d         = count_q;

      // Retire the presented entry and walk to its successor without a bubble
      if (deq_fire) begin
         valid_d[dequeue_id_q]      = 1'b0;
         next_valid_d[dequeue_id_q] = 1'b0;
         draining_d[dequeue_id_q]   = 1'b0;
         if (next_valid_q[dequeue_id_q]) begin
            dequeue_id_d                     = next_q[dequeue_id_q];
            draining_d[next_q[dequeue_id_q]] = 1'b1;
         end else begin
            dequeue_valid_d = 1'b0;
         end
      end

      // A fill closes the whole chain of its line: every undrained entry of that line
      // belongs to the filled chain, so later misses to the line start a fresh chain
      if (fill_fire) begin
         dequeue_valid_d     = 1'b1;
         dequeue_id_d        = fill_id;
         draining_d[fill_id] = 1'b1;
         for (int i = 0; i < MSHR_SIZE; i++) begin
            if (valid_q[i] && !draining_q[i] && (addr_q[i] == fill_addr)) begin
               draining_d[i] = 1'b1;
            end
         end
      end

      // Allocate a new entry, linking it behind the open tail of its line
      if (alloc_fire) begin
         valid_d[free_id]      = 1'b1;
         next_valid_d[free_id] = 1'b0;
         draining_d[free_id]   = fill_fire && tail_hit && (allocate_addr == fill_addr);
         addr_d[free_id]       = allocate_addr;
         data_d[free_id]       = allocate_data;
         if (tail_hit) begin
            next_d[tail_id]       = free_id;
            next_valid_d[tail_id] = 1'b1;
         end
      end

      case ({alloc_fire, deq_fire})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q         <= '0;
         next_valid_q    <= '0;
         draining_q      <= '0;
         dequeue_valid_q <= 1'b0;
         dequeue_id_q    <= '0;
         count_q         <= '0;
      end else begin
         valid_q         <= valid_d;
         next_valid_q    <= next_valid_d;
         draining_q      <= draining_d;
         dequeue_valid_q <= dequeue_valid_d;
         dequeue_id_q    <= dequeue_id_d;
         count_q         <= count_d;
      end
   end

   // Payload and link storage, written only on allocate
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      next_q <= next_d;
   end

   // Fills must target a valid, undrained chain head
   a_fill_head: assert property (@(posedge clk) disable iff (reset)
      fill_fire |-> (valid_q[fill_id] && !draining_q[fill_id] && !fill_is_linked));

endmodule

// File: tb/tb_vx_mshr_linked.sv
// tb/tb_vx_mshr_linked.sv - scoreboard bench for vx_mshr_linked
module tb_vx_mshr_linked;

   localparam int N  = 4;
   localparam int AW = 26;
   localparam int DW = 64;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          allocate_valid;
   logic [AW-1:0] allocate_addr;
   logic [DW-1:0] allocate_data;
   logic          allocate_ready;
   logic [IW-1:0] allocate_id;
   logic          allocate_pending;
   logic          fill_valid;
   logic [IW-1:0] fill_id;
   logic          fill_ready;
   logic          dequeue_valid;
   logic          dequeue_ready;
   logic [IW-1:0] dequeue_id;
   logic [AW-1:0] dequeue_addr;
   logic [DW-1:0] dequeue_data;
   logic          full;
   logic          empty;
   logic [IW:0]   count;

   always #5 clk = ~clk;

   vx_mshr_linked #(
      .MSHR_SIZE      (N),
      .LINE_ADDR_WIDTH(AW),
      .DATA_WIDTH     (DW),
      .MSHR_ADDR_WIDTH(IW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .allocate_valid  (allocate_valid),
      .allocate_addr   (allocate_addr),
      .allocate_data   (allocate_data),
      .allocate_ready  (allocate_ready),
      .allocate_id     (allocate_id),
      .allocate_pending(allocate_pending),
      .fill_valid      (fill_valid),
      .fill_id         (fill_id),
      .fill_ready      (fill_ready),
      .dequeue_valid   (dequeue_valid),
      .dequeue_ready   (dequeue_ready),
      .dequeue_id      (dequeue_id),
      .dequeue_addr    (dequeue_addr),
      .dequeue_data    (dequeue_data),
      .full            (full),
      .empty           (empty),
      .count           (count)
   );

   typedef struct {
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.id   = id;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      allocate_valid = 1'b0;
      fill_valid     = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic do_alloc(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [IW-1:0] eid, input logic ep);
      allocate_valid = 1'b1;
      allocate_addr  = a;
      allocate_data  = d;
      #1;
      check("alloc_ready", 64'(allocate_ready), 64'(1));
      check("alloc_id", 64'(allocate_id), 64'(eid));
      check("alloc_pending", 64'(allocate_pending), 64'(ep));
      tick();
      allocate_valid = 1'b0;
   endtask

   task automatic do_fill(input logic [IW-1:0] id);
      fill_valid = 1'b1;
      fill_id    = id;
      #1;
      check("fill_ready", 64'(fill_ready), 64'(1));
      tick();
      fill_valid = 1'b0;
   endtask

   // Scoreboard monitor: every dequeue handshake must match the oldest expected entry
   always @(negedge clk) begin
      if (!reset && dequeue_valid && dequeue_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL deq_unexpected: got id %0d, expected no dequeue", dequeue_id);
         end else begin
            mon_e = exp_q.pop_front();
            check("deq_id", 64'(dequeue_id), 64'(mon_e.id));
            check("deq_addr", 64'(dequeue_addr), 64'(mon_e.addr));
            check("deq_data", dequeue_data, mon_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      allocate_valid = 1'b0;
      allocate_addr  = '0;
      allocate_data  = '0;
      fill_valid     = 1'b0;
      fill_id        = '0;
      dequeue_ready  = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_deq_valid", 64'(dequeue_valid), 64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_full", 64'(full), 64'(0));
      check("rst_alloc_ready", 64'(allocate_ready), 64'(1));
      check("rst_alloc_id", 64'(allocate_id), 64'(0));

      // Two misses to one line form a chain that drains back to back
      do_alloc(26'h10, 64'hA0A0_0000_0000_0001, 2'd0, 1'b0);
      do_alloc(26'h10, 64'hA0A0_0000_0000_0002, 2'd1, 1'b1);
      check("chain_count", 64'(count), 64'(2));
      push(2'd0, 26'h10, 64'hA0A0_0000_0000_0001);
      push(2'd1, 26'h10, 64'hA0A0_0000_0000_0002);
      do_fill(2'd0);
      check("chain_first_valid", 64'(dequeue_valid), 64'(1));
      check("chain_first_id", 64'(dequeue_id), 64'(0));
      tick();
      check("chain_second_valid", 64'(dequeue_valid), 64'(1));
      check("chain_second_id", 64'(dequeue_id), 64'(1));
      tick();
      check("chain_done_valid", 64'(dequeue_valid), 64'(0));
      check("chain_done_empty", 64'(empty), 64'(1));

      // Fill to capacity, free one entry, then allocate and dequeue in one cycle
      for (int i = 0; i < N; i++) begin
         do_alloc(AW'(32'h20 + i), DW'(64'hB000 + i), IW'(i), 1'b0);
      end
      check("full_flag", 64'(full), 64'(1));
      check("full_alloc_ready", 64'(allocate_ready), 64'(0));
      check("full_count", 64'(count), 64'(4));
      push(2'd2, 26'h22, 64'hB002);
      do_fill(2'd2);
      check("full_while_present", 64'(allocate_ready), 64'(0));
      tick();
      check("freed_alloc_ready", 64'(allocate_ready), 64'(1));
      check("freed_count", 64'(count), 64'(3));
      check("freed_alloc_id", 64'(allocate_id), 64'(2));
      push(2'd0, 26'h20, 64'hB000);
      do_fill(2'd0);
      do_alloc(26'h30, 64'hC030, 2'd2, 1'b0);
      check("both_fire_count", 64'(count), 64'(3));
      check("both_fire_deq_valid", 64'(dequeue_valid), 64'(0));
      check("both_fire_next_id", 64'(allocate_id), 64'(0));
      do_reset();

      // Backpressure holds the presented entry
      do_alloc(26'h10, 64'hD001, 2'd0, 1'b0);
      do_alloc(26'h10, 64'hD002, 2'd1, 1'b1);
      dequeue_ready = 1'b0;
      do_fill(2'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_valid", 64'(dequeue_valid), 64'(1));
         check("hold_id", 64'(dequeue_id), 64'(0));
         check("hold_count", 64'(count), 64'(2));
      end
      push(2'd0, 26'h10, 64'hD001);
      push(2'd1, 26'h10, 64'hD002);
      dequeue_ready = 1'b1;
      tick();
      tick();
      check("hold_drained", 64'(empty), 64'(1));
      do_reset();

      // A miss to a draining line starts a new chain, filled on its own
      do_alloc(26'h40, 64'hE001, 2'd0, 1'b0);
      do_alloc(26'h40, 64'hE002, 2'd1, 1'b1);
      dequeue_ready = 1'b0;
      do_fill(2'd0);
      do_alloc(26'h40, 64'hE003, 2'd2, 1'b0);
      check("newchain_count", 64'(count), 64'(3));
      push(2'd0, 26'h40, 64'hE001);
      push(2'd1, 26'h40, 64'hE002);
      dequeue_ready = 1'b1;
      tick();
      tick();
      check("newchain_old_done", 64'(dequeue_valid), 64'(0));
      check("newchain_left", 64'(count), 64'(1));
      push(2'd2, 26'h40, 64'hE003);
      do_fill(2'd2);
      check("newchain_head_id", 64'(dequeue_id), 64'(2));
      tick();
      check("newchain_single", 64'(dequeue_valid), 64'(0));
      check("newchain_empty", 64'(empty), 64'(1));

      // Allocating while the tail itself is being dequeued does not link
      do_alloc(26'h50, 64'hF001, 2'd0, 1'b0);
      push(2'd0, 26'h50, 64'hF001);
      do_fill(2'd0);
      do_alloc(26'h50, 64'hF002, 2'd1, 1'b0);
      check("tailrace_deq_valid", 64'(dequeue_valid), 64'(0));
      check("tailrace_count", 64'(count), 64'(1));
      push(2'd1, 26'h50, 64'hF002);
      do_fill(2'd1);
      tick();
      check("tailrace_empty", 64'(empty), 64'(1));
      do_reset();

      // Reset in the middle of draining a three-entry chain
      do_alloc(26'h60, 64'h6001, 2'd0, 1'b0);
      do_alloc(26'h60, 64'h6002, 2'd1, 1'b1);
      do_alloc(26'h60, 64'h6003, 2'd2, 1'b1);
      push(2'd0, 26'h60, 64'h6001);
      do_fill(2'd0);
      tick();
      check("middrain_id", 64'(dequeue_id), 64'(1));
      dequeue_ready = 1'b0;
      reset         = 1'b1;
      tick();
      reset         = 1'b0;
      dequeue_ready = 1'b1;
      check("postrst_deq_valid", 64'(dequeue_valid), 64'(0));
      check("postrst_count", 64'(count), 64'(0));
      check("postrst_alloc_id", 64'(allocate_id), 64'(0));
      check("postrst_alloc_ready", 64'(allocate_ready), 64'(1));
      tick();
      tick();
      check("postrst_no_deq", 64'(dequeue_valid), 64'(0));

      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_mshr_linked.md
VX_MSHR_LINKED -- requirements
Module: VX_mshr_linked

Interface
REQ-001 SHALL have parameter MSHR_SIZE, default 8: number of entries, power of two, 2..64.
REQ-002 SHALL have parameter LINE_ADDR_WIDTH, default 26: line address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: per-entry payload width.
REQ-004 SHALL have parameter MSHR_ADDR_WIDTH, default $clog2(MSHR_SIZE): entry index width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock; reset input 1 synchronous active-high reset.
REQ-006 SHALL have allocate_valid input 1, allocate_addr input LINE_ADDR_WIDTH, allocate_data input DATA_WIDTH, allocate_ready output 1, allocate_id output MSHR_ADDR_WIDTH, allocate_pending output 1 (1 = chained behind an earlier miss to the same line).
REQ-007 SHALL have fill_valid input 1, fill_id input MSHR_ADDR_WIDTH (chain head), fill_ready output 1.
REQ-008 SHALL have dequeue_valid output 1, dequeue_ready input 1, dequeue_id output MSHR_ADDR_WIDTH, dequeue_addr output LINE_ADDR_WIDTH, dequeue_data output DATA_WIDTH.
REQ-009 SHALL have full output 1, empty output 1, count output MSHR_ADDR_WIDTH+1.

Function
REQ-010 Per-entry state SHALL be: valid, addr, data, next pointer, next_valid, draining.
REQ-011 allocate_ready SHALL be ~full; allocate_id SHALL be the lowest index with valid=0, combinational from registered state.
REQ-012 On allocate fire: entry valid=1, next_valid=0, draining=0; addr and data written; the entry is visible next cycle.
REQ-013 allocate_pending SHALL be combinational: 1 iff a valid entry exists with the same addr, draining=0 and next_valid=0 (the tail).
REQ-014 On allocate fire with allocate_pending=1, that tail's next SHALL be set to allocate_id and its next_valid to 1.
REQ-015 fill_ready SHALL be ~dequeue_valid; fill_valid && fill_ready SHALL set draining on fill_id and present it on dequeue the next cycle (1-cycle latency).
REQ-016 Dequeue outputs SHALL come from a registered dequeue_id; dequeue_addr and dequeue_data SHALL be valid in the same cycle as dequeue_valid.
REQ-017 Dequeue fire SHALL set the entry's valid to 0.
REQ-018 On dequeue fire with next_valid=1: dequeue_id SHALL be next, the next entry's draining SHALL be 1, and dequeue_valid SHALL stay 1 with no bubble.
REQ-019 On dequeue fire with next_valid=0, dequeue_valid SHALL be 0 the next cycle.
REQ-020 dequeue_valid/id SHALL hold stable while dequeue_ready=0.
REQ-021 An entry freed by dequeue SHALL NOT be allocatable until the following cycle.
REQ-022 Allocate matching a draining chain's address SHALL return pending=0 and start a new chain.
REQ-023 Allocate on the same cycle the tail is dequeued SHALL NOT link (the tail is draining); pending=0.
REQ-024 count SHALL equal the number of valid entries, updated by +1 allocate, -1 dequeue, net 0 when both fire; full = (count==MSHR_SIZE); empty = (count==0).
REQ-025 A simulation assertion SHALL fire on fill of an invalid entry, of a draining entry, or of a non-head entry.

Reset
REQ-026 While reset=1 on a clk edge, all valid, next_valid and draining bits SHALL clear; dequeue_valid=0, count=0, empty=1, full=0.
REQ-027 allocate_ready SHALL be 1 the cycle after reset deasserts; reset mid-drain SHALL abandon the chain with no further dequeue.
REQ-028 addr, data and next storage SHALL NOT require reset.

Verification
REQ-029 MSHR_SIZE=4, allocate A=0x10 -> id0 pending0; A again -> id1 pending1; fill id0 -> dequeue id0 then id1 on back-to-back cycles; then empty=1.
REQ-030 Allocate 4 distinct addrs -> full=1, allocate_ready=0; dequeue one -> allocate_ready=1 next cycle, count=3.
REQ-031 Chain A (id0,id1), dequeue_ready held 0 for 3 cycles -> dequeue_id stays 0, count stays 2.
REQ-032 Draining chain A, allocate A -> pending=0, new head; later fill of it drains only that entry.
REQ-033 Allocate and dequeue fire in the same cycle -> count unchanged; freed id not issued that cycle.
REQ-034 Reset asserted mid-drain of a 3-entry chain -> next cycle dequeue_valid=0, count=0, allocate_id=0.
